// File: rtl/ham_enc_sched.sv
// Round-robin scheduler feeding one shared Hamming(7,4) encoder into a single-entry output register.
// Optional statistics counters are built when HAM_SCHED_STATS_EN is defined.

module ham_encoder (
  input  logic [3:0] d,
  output logic [6:0] c
);
  assign c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
endmodule

module ham_enc_sched #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic [6:0]           out_data,
  output logic [SRC_W-1:0]     out_src,
  input  logic                 out_ready
`ifdef HAM_SCHED_STATS_EN
  ,
  output logic [15:0]          enc_count,
  output logic [15:0]          stall_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg;
  logic [6:0]       out_data_reg;
  logic [SRC_W-1:0] out_src_reg;
  logic [SRC_W-1:0] rr_ptr_reg;

  logic             slot_free;
  logic             grant_any;
  logic             grant_fire;
  logic [SRC_W-1:0] grant_idx;
  logic [3:0]       grant_data;
  logic [6:0]       grant_code;

  // Scan offsets from the highest down so the closest valid requester above rr_ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_reg) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = idx[SRC_W-1:0];
        grant_data = req_data[4*idx +: 4];
      end
    end
  end

  assign slot_free  = (state_reg == EMPTY) || out_ready;
  assign grant_fire = slot_free && grant_any && !rst;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_fire && (int'(grant_idx) == gi);
    end
  endgenerate

  ham_encoder u_enc (
    .d (grant_data),
    .c (grant_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      out_data_reg <= '0;
      out_src_reg  <= '0;
      rr_ptr_reg   <= '0;
    end else if (grant_fire) begin
      state_reg    <= FULL;
      out_data_reg <= grant_code;
      out_src_reg  <= grant_idx;
      if (int'(grant_idx) == N_REQ - 1)
        rr_ptr_reg <= '0;
      else
        rr_ptr_reg <= grant_idx + 1'b1;
    end else if (out_ready) begin
      state_reg <= EMPTY;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

`ifdef HAM_SCHED_STATS_EN
  logic [15:0] enc_count_reg;
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count_reg   <= '0;
      stall_count_reg <= '0;
    end else begin
      if (grant_fire && enc_count_reg != 16'hFFFF)
        enc_count_reg <= enc_count_reg + 16'd1;
      if (state_reg == FULL && !out_ready && stall_count_reg != 16'hFFFF)
        stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign enc_count   = enc_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_ham_enc_sched.sv
// Self-checking bench for ham_enc_sched: directed test-plan scenarios plus randomized traffic
// against a position-based Hamming reference and a queue-free round-robin model.

module tb_ham_enc_sched;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [4*N-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [6:0]    out_data;
  logic [SW-1:0] out_src;
  logic          out_ready = 1'b0;
`ifdef HAM_SCHED_STATS_EN
  logic [15:0]   enc_count;
  logic [15:0]   stall_count;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int         ref_ptr = 0;
  logic       ref_valid = 1'b0;
  logic [6:0] ref_data = '0;
  int         ref_src = 0;
  int         ref_enc_cnt = 0;
  int         ref_stall_cnt = 0;

  always #5 clk = ~clk;

  ham_enc_sched #(.N_REQ(N), .SRC_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
`ifdef HAM_SCHED_STATS_EN
    ,
    .enc_count  (enc_count),
    .stall_count(stall_count)
`endif
  );

  // Classic Hamming layout: positions 1..7, parity at powers of two covering positions sharing that bit.
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [7:1] pos;
    logic       x;
    pos    = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      x = 1'b0;
      for (int j = 3; j <= 7; j++)
        if ((j & p) != 0) x = x ^ pos[j];
      pos[p] = x;
    end
    return pos[7:1];
  endfunction

  function automatic int ref_grant();
    int idx;
    if (rst) return -1;
    if (ref_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (ref_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = ref_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and update the model from the inputs present before the edge.
  task automatic tick();
    int g;
    logic [3:0] d;
    logic stall;
    g     = ref_grant();
    stall = ref_valid && !out_ready;
    d     = (g >= 0) ? req_data[4*g +: 4] : 4'h0;
    @(posedge clk);
    if (stall && ref_stall_cnt < 16'hFFFF) ref_stall_cnt++;
    if (g >= 0) begin
      ref_data  = ref_enc(d);
      ref_src   = g;
      ref_valid = 1'b1;
      ref_ptr   = (g + 1) % N;
      if (ref_enc_cnt < 16'hFFFF) ref_enc_cnt++;
      $display("[%0t] grant src=%0d data=%h code=%h", $time, g, d, ref_data);
    end else if (out_ready) begin
      ref_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    ref_ptr = 0; ref_valid = 1'b0; ref_data = '0; ref_src = 0;
    ref_enc_cnt = 0; ref_stall_cnt = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    out_ready = 1'b1;
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++;
    if ({out_valid, out_data, out_src} !== '0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h s=%0d expected all 0", out_valid, out_data, out_src);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_first_word();
    req_valid = 4'b0001;
    req_data  = 16'h000B;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h55 || out_src !== 2'd0) begin
      errors++; $display("FAIL first_word: got v=%b d=%h s=%0d expected v=1 d=55 s=0", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] din [4] = '{4'h0, 4'h1, 4'h2, 4'hF};
    logic [6:0] want [4] = '{7'h00, 7'h07, 7'h19, 7'h7F};
    out_ready = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      req_data = {12'h000, din[i]};
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 0001", i, req_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== want[i]) begin
        errors++; $display("FAIL b2b_word[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, want[i]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int want [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    out_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      req_data = {$urandom} [15:0];
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_src) != want[i] || out_data !== ref_data) begin
        errors++; $display("FAIL rr_seq[%0d]: got s=%0d d=%h expected s=%0d d=%h", i, out_src, out_data, want[i], ref_data);
      end
    end
  endtask

  task automatic test_stall();
    logic [6:0] held_d;
    logic [SW-1:0] held_s;
    held_d = out_data;
    held_s = out_src;
    out_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      req_data = {$urandom} [15:0];
      #1;
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, req_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_src !== held_s || out_data !== ref_data) begin
        errors++; $display("FAIL stall_hold[%0d]: got d=%h s=%0d expected d=%h s=%0d", i, out_data, out_src, held_d, held_s);
      end
    end
`ifdef HAM_SCHED_STATS_EN
    checks++;
    if (stall_count !== 16'd5 || int'(stall_count) != ref_stall_cnt) begin
      errors++; $display("FAIL stall_count: got %0d expected 5", stall_count);
    end
    checks++;
    if (int'(enc_count) != ref_enc_cnt) begin
      errors++; $display("FAIL enc_count: got %0d expected %0d", enc_count, ref_enc_cnt);
    end
`endif
    req_valid = '0;
  endtask

  task automatic test_drain_grant();
    apply_reset();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_data  = 16'h0003;
    tick();
    req_valid = 4'b0100;
    req_data  = 16'h0900;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL drain_ready: got %b expected 0100", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== ref_enc(4'h9)) begin
      errors++; $display("FAIL drain_word: got v=%b s=%0d d=%h expected v=1 s=2 d=%h", out_valid, out_src, out_data, ref_enc(4'h9));
    end
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL drain_next_ptr: got %b expected 1000", req_ready); end
    tick();
    checks++;
    if (out_src !== 2'd3) begin errors++; $display("FAIL drain_next_src: got %0d expected 3", out_src); end
    req_valid = '0;
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = 16'h0F00;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstfull_setup: got v=%b expected 1", out_valid); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({out_valid, out_data, out_src} !== '0 || req_ready !== '0) begin
      errors++; $display("FAIL rstfull_clear: got v=%b d=%h s=%0d r=%b expected all 0", out_valid, out_data, out_src, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstfull_priority: got %b expected 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = {$urandom} [N-1:0];
      req_data  = {$urandom} [15:0];
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++;
      if (req_ready !== ref_ready()) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready, ref_ready());
      end
      tick();
      checks++;
      if (out_valid !== ref_valid || out_data !== ref_data || int'(out_src) != ref_src) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                           i, out_valid, out_data, out_src, ref_valid, ref_data, ref_src);
      end
    end
`ifdef HAM_SCHED_STATS_EN
    checks++;
    if (int'(enc_count) != ref_enc_cnt || int'(stall_count) != ref_stall_cnt) begin
      errors++; $display("FAIL rand_stats: got e=%0d s=%0d expected e=%0d s=%0d", enc_count, stall_count, ref_enc_cnt, ref_stall_cnt);
    end
`endif
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_round_robin();
    test_stall();
    test_drain_grant();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
